exe_unit_mc: RTL and testbench
==============================

# exe_unit_mc

Parametrised execute stage for the pipelined CPU: selects ALU operands from the register file, immediate, shift amount or the MEM/WB forwarding paths, and computes single-cycle ALU results plus iterative unsigned multiply/divide/remainder. Sits between the ID/EXE and EXE/MEM pipeline registers. It registers its result and uses a valid/ready handshake on both sides so the hazard unit can stall on multi-cycle operations.

## Interface
- WIDTH, 32: datapath width (≥8, power of two)
- SA_W, 5: shift-amount width, must equal log2(WIDTH)
- SA_LSB, 5: LSB of the shift-amount field inside exe_imm
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  kill the in-flight op and the held result
- in_valid  in  1  operation presented
- in_ready  out  1  op accepted on a cycle where in_valid&in_ready
- exe_aluc  in  4  operation code
- exe_a, exe_b  in  WIDTH  register-file operands
- exe_imm  in  WIDTH  extended immediate
- exe_a_select, exe_b_select  in  2  0=reg, 1=sa (a) / imm (b), 2=mem_forward, 3=WB data
- mem_forward, wb_alu_forward, wb_mo_forward  in  WIDTH  forwarded values
- wb_m2reg  in  1  WB data = wb_mo_forward when 1, else wb_alu_forward
- out_valid  out  1  result held
- out_ready  in  1  downstream consumes result on out_valid&out_ready
- exe_alu  out  WIDTH  result
- z  out  1  exe_alu == 0
- busy  out  1  multi-cycle op iterating

## Operation
- Operand muxes combinational; sa = zero-extended exe_imm[SA_LSB+SA_W-1:SA_LSB]. Operands sampled only on the accepting edge.
- aluc 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA: shift value is b, amount a[SA_W-1:0]. All modulo 2^WIDTH, no overflow flag.
- aluc 8 MULU (low WIDTH bits of a*b), 9 DIVU (quotient), 10 REMU (remainder): iterative, one bit per cycle (shift-add / restoring).
- Divide by zero: DIVU = all ones, REMU = a.
- aluc 11–15: result 0, single-cycle.
- FSM IDLE, MUL, DIV. IDLE + accept of 0–7/11–15: result straight into output register, stay IDLE. IDLE + accept of 8: →MUL; 9/10: →DIV; counter cleared. MUL/DIV: one iteration per cycle; after iteration WIDTH result written to output register, out_valid set, →IDLE.
- in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush. Accept with out_valid&out_ready in the same cycle: old result consumed, new one loaded.
- Output register holds exe_alu/z stable while out_valid & !out_ready.
- z is registered together with exe_alu.
- flush: state→IDLE, out_valid→0, counter→0; no accept that cycle; exe_alu keeps its old value.

## Timing
- Reset: state IDLE, out_valid 0, exe_alu 0, z 1, busy 0, in_ready 0 during reset, 1 on the first cycle after.
- Single-cycle ops: out_valid high the cycle after the accepting edge (latency 1); back-to-back throughput 1/cycle when out_ready held high.
- MUL/DIV: busy high from the edge after accept until the edge that sets out_valid; out_valid rises WIDTH edges after the accepting edge (32 cycles at default); in_ready low throughout.
- Reset or flush mid-iteration abandons the op; no result ever appears for it.
- Forwarding values must be valid in the accepting cycle only.

## Structure
- Package exe_pkg: aluc constants (ALU_ADD … ALU_REMU), FSM state enum, select-code constants.
- Sub-module exe_muldiv: iterative unsigned multiply/divide core with start/flush/done, parametrised by WIDTH; exe_unit_mc holds muxes, single-cycle ALU, handshake and output register.

## Test plan
- ADD a_sel=0 b_sel=1, exe_a=5, exe_imm=7 → exe_alu=12, z=0, out_valid one cycle after accept.
- SUB, b_sel=2, exe_a=9, mem_forward=9 → exe_alu=0, z=1; a_sel=3, wb_m2reg=1, wb_mo_forward=0x10, SLL by sa: exe_b=1, exe_imm[9:5]=4 → 0x10 shifted wrongly not allowed: a=sa=4 → exe_alu=0x10.
- MULU 0xFFFF_FFFF × 3 → 0xFFFF_FFFD after exactly 32 cycles, busy high 32 cycles, in_ready low meanwhile.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 5/0 → 0xFFFF_FFFF; REMU 5/0 → 5.
- out_ready low for 3 cycles after ADD result → exe_alu stable, in_ready low; ADD stream with out_ready high → one result per cycle.
- flush at iteration 10 of DIVU, and reset at iteration 10 of MULU → out_valid never rises for that op, next ADD accepted the following cycle and completes normally.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU op codes, operand-select codes
// and the multi-cycle sequencing states.
package exe_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_MULU = 4'd8;
   localparam logic [3:0] ALU_DIVU = 4'd9;
   localparam logic [3:0] ALU_REMU = 4'd10;

   // Code 1 means shift amount on the A side and immediate on the B side.
   localparam logic [1:0] SEL_REG    = 2'd0;
   localparam logic [1:0] SEL_SA_IMM = 2'd1;
   localparam logic [1:0] SEL_MEM    = 2'd2;
   localparam logic [1:0] SEL_WB     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } exe_state_t;

   function automatic logic is_multi(input logic [3:0] aluc);
      return (aluc == ALU_MULU) || (aluc == ALU_DIVU) || (aluc == ALU_REMU);
   endfunction

endpackage

// File: rtl/exe_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide/remainder (restoring),
// one bit per cycle; done is asserted during the final iteration cycle.
module exe_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_rem,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic             active;
   logic [CNT_W-1:0] count;
   logic             div_mode;
   logic             rem_mode;
   logic             div_zero;
   // Multiply: acc = partial product, opnd = multiplicand, shreg = multiplier.
   // Divide:   acc = remainder, opnd = divisor, shreg = dividend -> quotient.
   logic [WIDTH-1:0] acc, opnd, shreg;
   logic [WIDTH-1:0] acc_nxt, opnd_nxt, shreg_nxt, diff;
   logic [WIDTH:0]   rem_sh;
   logic             ge;

   // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
   always_comb begin
      rem_sh    = {acc, shreg[WIDTH-1]};
      ge        = (rem_sh >= {1'b0, opnd});
      diff      = rem_sh[WIDTH-1:0] - opnd;
      acc_nxt   = acc;
      opnd_nxt  = opnd;
      shreg_nxt = shreg;
      if (!div_mode) begin
         acc_nxt   = acc + (shreg[0] ? opnd : '0);
         opnd_nxt  = opnd << 1;
         shreg_nxt = shreg >> 1;
      end else if (div_zero) begin
         shreg_nxt = {shreg[WIDTH-2:0], 1'b1};
      end else begin
         acc_nxt   = ge ? diff : rem_sh[WIDTH-1:0];
         shreg_nxt = {shreg[WIDTH-2:0], ge};
      end
   end

   assign done   = active && (count == LAST);
   assign result = (div_mode && !rem_mode) ? shreg_nxt : acc_nxt;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         active <= 1'b0;
         count  <= '0;
      end else if (start) begin
         active <= 1'b1;
         count  <= '0;
      end else if (active) begin
         count <= count + 1'b1;
         if (count == LAST) active <= 1'b0;
      end
   end

   // NOTE: datapath registers are not reset; nothing reads them unless active.
   always_ff @(posedge clock) begin
      if (start) begin
         div_mode <= is_div;
         rem_mode <= is_rem;
         div_zero <= is_div && (b == '0);
         if (is_div) begin
            // Divide by zero parks the dividend as remainder and all-ones as quotient.
            acc   <= (b == '0) ? a : '0;
            opnd  <= b;
            shreg <= (b == '0) ? '1 : a;
         end else begin
            acc   <= '0;
            opnd  <= a;
            shreg <= b;
         end
      end else if (active) begin
         acc   <= acc_nxt;
         opnd  <= opnd_nxt;
         shreg <= shreg_nxt;
      end
   end

endmodule

// File: rtl/exe_unit_mc.sv
// Execute stage: operand/forwarding muxes, single-cycle ALU, iterative
// mul/div sequencing and a registered valid/ready result.
module exe_unit_mc
   import exe_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int SA_W   = 5,
   parameter int SA_LSB = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       exe_aluc,
   input  logic [WIDTH-1:0] exe_a,
   input  logic [WIDTH-1:0] exe_b,
   input  logic [WIDTH-1:0] exe_imm,
   input  logic [1:0]       exe_a_select,
   input  logic [1:0]       exe_b_select,
   input  logic [WIDTH-1:0] mem_forward,
   input  logic [WIDTH-1:0] wb_alu_forward,
   input  logic [WIDTH-1:0] wb_mo_forward,
   input  logic             wb_m2reg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] exe_alu,
   output logic             z,
   output logic             busy
);

   exe_state_t       state;
   logic [WIDTH-1:0] sa, wb_data, opa, opb, alu_res, md_result;
   logic [SA_W-1:0]  shamt;
   logic             accept, md_start, md_done;

   assign sa      = {{(WIDTH-SA_W){1'b0}}, exe_imm[SA_LSB+SA_W-1:SA_LSB]};
   assign wb_data = wb_m2reg ? wb_mo_forward : wb_alu_forward;

   always_comb begin
      opa = exe_a;
      case (exe_a_select)
         SEL_SA_IMM: opa = sa;
         SEL_MEM:    opa = mem_forward;
         SEL_WB:     opa = wb_data;
         default:    opa = exe_a;
      endcase
      opb = exe_b;
      case (exe_b_select)
         SEL_SA_IMM: opb = exe_imm;
         SEL_MEM:    opb = mem_forward;
         SEL_WB:     opb = wb_data;
         default:    opb = exe_b;
      endcase
   end

   assign shamt = opa[SA_W-1:0];

   always_comb begin
      alu_res = '0;
      case (exe_aluc)
         ALU_ADD: alu_res = opa + opb;
         ALU_SUB: alu_res = opa - opb;
         ALU_AND: alu_res = opa & opb;
         ALU_OR:  alu_res = opa | opb;
         ALU_XOR: alu_res = opa ^ opb;
         ALU_SLL: alu_res = opb << shamt;
         ALU_SRL: alu_res = opb >> shamt;
         ALU_SRA: alu_res = $signed(opb) >>> shamt;
         default: alu_res = '0;
      endcase
   end

   // A held result may be replaced on the same edge it is consumed.
   assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready) && !flush && !reset;
   assign accept   = in_valid && in_ready;
   assign md_start = accept && is_multi(exe_aluc);
   assign busy     = (state != ST_IDLE);

   exe_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clock  (clock),
      .reset  (reset),
      .flush  (flush),
      .start  (md_start),
      .is_div (exe_aluc != ALU_MULU),
      .is_rem (exe_aluc == ALU_REMU),
      .a      (opa),
      .b      (opb),
      .done   (md_done),
      .result (md_result)
   );

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (md_start) state <= (exe_aluc == ALU_MULU) ? ST_MUL : ST_DIV;
            end
            ST_MUL, ST_DIV: begin
               if (md_done) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         exe_alu   <= '0;
         z         <= 1'b1;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept && !md_start) begin
         exe_alu   <= alu_res;
         z         <= (alu_res == '0);
         out_valid <= 1'b1;
      end else if (md_done) begin
         exe_alu   <= md_result;
         z         <= (md_result == '0);
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_exe_unit_mc.sv
// Self-checking bench for exe_unit_mc: directed and random operations checked
// against an arithmetic reference model, plus handshake and abort scenarios.
module tb_exe_unit_mc;
   import exe_pkg::*;

   localparam int W      = 32;
   localparam int SA_W   = 5;
   localparam int SA_LSB = 5;

   logic         clock = 1'b0;
   logic         reset, flush, in_valid, in_ready;
   logic [3:0]   exe_aluc;
   logic [W-1:0] exe_a, exe_b, exe_imm, mem_forward, wb_alu_forward, wb_mo_forward;
   logic [1:0]   exe_a_select, exe_b_select;
   logic         wb_m2reg, out_valid, out_ready, z, busy;
   logic [W-1:0] exe_alu;

   int n_cmp = 0;
   int n_err = 0;

   exe_unit_mc #(.WIDTH(W), .SA_W(SA_W), .SA_LSB(SA_LSB)) dut (
      .clock          (clock),
      .reset          (reset),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .exe_aluc       (exe_aluc),
      .exe_a          (exe_a),
      .exe_b          (exe_b),
      .exe_imm        (exe_imm),
      .exe_a_select   (exe_a_select),
      .exe_b_select   (exe_b_select),
      .mem_forward    (mem_forward),
      .wb_alu_forward (wb_alu_forward),
      .wb_mo_forward  (wb_mo_forward),
      .wb_m2reg       (wb_m2reg),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .exe_alu        (exe_alu),
      .z              (z),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model_wb();
      return wb_m2reg ? wb_mo_forward : wb_alu_forward;
   endfunction

   function automatic logic [W-1:0] model_opa();
      case (exe_a_select)
         2'd0:    return exe_a;
         2'd1:    return W'(exe_imm[SA_LSB +: SA_W]);
         2'd2:    return mem_forward;
         default: return model_wb();
      endcase
   endfunction

   function automatic logic [W-1:0] model_opb();
      case (exe_b_select)
         2'd0:    return exe_b;
         2'd1:    return exe_imm;
         2'd2:    return mem_forward;
         default: return model_wb();
      endcase
   endfunction

   function automatic logic [W-1:0] model_result(input logic [3:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
      int unsigned s;
      logic [2*W-1:0] p;
      logic [W-1:0] ones;
      s    = a % W;
      ones = '1;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return b << s;
         4'd6:  return b >> s;
         4'd7:  return (b >> s) | (b[W-1] ? ~(ones >> s) : '0);
         4'd8:  begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; return p[W-1:0]; end
         4'd9:  return (b == 0) ? ones : a / b;
         4'd10: return (b == 0) ? a : a % b;
         default: return '0;
      endcase
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic rand_data();
      exe_a          = $urandom;
      exe_b          = $urandom;
      exe_imm        = $urandom;
      mem_forward    = $urandom;
      wb_alu_forward = $urandom;
      wb_mo_forward  = $urandom;
      wb_m2reg       = 1'($urandom_range(0, 1));
   endtask

   task automatic set_op(input logic [3:0] op, input logic [1:0] asel, input logic [1:0] bsel);
      exe_aluc     = op;
      exe_a_select = asel;
      exe_b_select = bsel;
   endtask

   task automatic rand_single_op();
      int unsigned op;
      op = $urandom_range(0, 12);
      if (op > 7) op = op + 3;
      set_op(4'(op), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
   endtask

   // Called at a negedge; returns just after the accepting edge with inputs scrambled.
   task automatic accept_op(input string name, output logic [W-1:0] exp);
      int t;
      t   = 0;
      exp = model_result(exe_aluc, model_opa(), model_opb());
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && t < 100) begin
         @(negedge clock);
         t++;
      end
      n_cmp++;
      if (t >= 100) begin
         n_err++;
         $display("FAIL %s accept: in_ready=%b, wanted 1 within 100 cycles", name, in_ready);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      rand_data();
   endtask

   task automatic do_single(input string name, output logic [W-1:0] exp);
      accept_op(name, exp);
      @(negedge clock);
      n_cmp++;
      if (out_valid !== 1'b1 || exe_alu !== exp || z !== (exp == '0)) begin
         n_err++;
         $display("FAIL %s: out_valid=%b exe_alu=%h z=%b, wanted 1 %h %b",
                  name, out_valid, exe_alu, z, exp, (exp == '0));
      end
   endtask

   task automatic do_multi(input string name);
      logic [W-1:0] exp;
      int lat, busy_cnt, rdy_low;
      lat = 0; busy_cnt = 0; rdy_low = 0;
      accept_op(name, exp);
      @(negedge clock);
      while (out_valid !== 1'b1 && lat < 3 * W) begin
         if (busy === 1'b1) busy_cnt++;
         if (in_ready === 1'b0) rdy_low++;
         @(negedge clock);
         lat++;
      end
      n_cmp++;
      if (lat != W) begin
         n_err++;
         $display("FAIL %s latency: %0d edges, wanted %0d", name, lat, W);
      end
      n_cmp++;
      if (busy_cnt != W || rdy_low != W) begin
         n_err++;
         $display("FAIL %s busy/in_ready: busy %0d cycles, in_ready low %0d cycles, wanted %0d",
                  name, busy_cnt, rdy_low, W);
      end
      n_cmp++;
      if (exe_alu !== exp || z !== (exp == '0) || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s result: exe_alu=%h z=%b busy=%b, wanted %h %b 0",
                  name, exe_alu, z, busy, exp, (exp == '0));
      end
   endtask

   task automatic watch_no_stale(input string name);
      int hi;
      hi = 0;
      repeat (W + 4) begin
         @(negedge clock);
         if (out_valid === 1'b1) hi++;
      end
      n_cmp++;
      if (hi != 0) begin
         n_err++;
         $display("FAIL %s stale result: out_valid high %0d cycles, wanted 0", name, hi);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || exe_alu !== '0 || z !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset state: in_ready=%b out_valid=%b exe_alu=%h z=%b busy=%b, wanted 0 0 0 1 0",
                  in_ready, out_valid, exe_alu, z, busy);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL after reset: in_ready=%b out_valid=%b, wanted 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_directed_single();
      logic [W-1:0] exp;
      rand_data(); set_op(ALU_ADD, SEL_REG, SEL_SA_IMM);
      exe_a = 5; exe_imm = 7;
      do_single("add_imm", exp);
      n_cmp++;
      if (exp !== 32'd12) begin n_err++; $display("FAIL add_imm model: %h, wanted 0000000c", exp); end
      rand_data(); set_op(ALU_SUB, SEL_REG, SEL_MEM);
      exe_a = 9; mem_forward = 9;
      do_single("sub_mem_zero", exp);
      rand_data(); set_op(ALU_SLL, SEL_SA_IMM, SEL_REG);
      exe_b = 1; exe_imm = 32'(4) << SA_LSB;
      do_single("sll_sa", exp);
      rand_data(); set_op(ALU_ADD, SEL_WB, SEL_SA_IMM);
      wb_m2reg = 1; wb_mo_forward = 32'h10; wb_alu_forward = 32'h999; exe_imm = 32'h20;
      do_single("add_wb_mo", exp);
      rand_data(); set_op(ALU_ADD, SEL_WB, SEL_WB);
      wb_m2reg = 0;
      do_single("add_wb_alu", exp);
      rand_data(); set_op(ALU_SRA, SEL_REG, SEL_REG);
      exe_a = 4; exe_b = 32'h8000_0000;
      do_single("sra_neg", exp);
      rand_data(); set_op(4'd13, SEL_REG, SEL_REG);
      do_single("undef_op", exp);
   endtask

   task automatic test_random_single();
      logic [W-1:0] exp;
      for (int i = 0; i < 40; i++) begin
         rand_data();
         rand_single_op();
         do_single($sformatf("rand_single_%0d", i), exp);
      end
   endtask

   task automatic test_muldiv();
      rand_data(); set_op(ALU_MULU, SEL_REG, SEL_REG);
      exe_a = 32'hFFFF_FFFF; exe_b = 3;
      do_multi("mulu_max_x3");
      rand_data(); set_op(ALU_DIVU, SEL_REG, SEL_REG); exe_a = 100; exe_b = 7;
      do_multi("divu_100_7");
      rand_data(); set_op(ALU_REMU, SEL_REG, SEL_REG); exe_a = 100; exe_b = 7;
      do_multi("remu_100_7");
      rand_data(); set_op(ALU_DIVU, SEL_REG, SEL_REG); exe_a = 5; exe_b = 0;
      do_multi("divu_by_zero");
      rand_data(); set_op(ALU_REMU, SEL_REG, SEL_REG); exe_a = 5; exe_b = 0;
      do_multi("remu_by_zero");
      for (int i = 0; i < 6; i++) begin
         rand_data();
         set_op(4'(8 + $urandom_range(0, 2)), 2'($urandom_range(0, 3)), SEL_REG);
         if (i % 2 == 0) exe_b = $urandom_range(1, 1000);
         do_multi($sformatf("rand_muldiv_%0d", i));
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] exp1, exp2;
      rand_data(); rand_single_op();
      do_single("bp_first", exp1);
      out_ready = 1'b0;
      rand_data(); set_op(ALU_XOR, SEL_REG, SEL_MEM);
      exp2 = model_result(exe_aluc, model_opa(), model_opb());
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clock);
         @(negedge clock);
         n_cmp++;
         if (out_valid !== 1'b1 || exe_alu !== exp1 || z !== (exp1 == '0) || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold_%0d: out_valid=%b exe_alu=%h z=%b in_ready=%b, wanted 1 %h %b 0",
                     k, out_valid, exe_alu, z, in_ready, exp1, (exp1 == '0));
         end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: in_ready=%b, wanted 1", in_ready);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      rand_data();
      @(negedge clock);
      n_cmp++;
      if (out_valid !== 1'b1 || exe_alu !== exp2) begin
         n_err++;
         $display("FAIL bp_second: out_valid=%b exe_alu=%h, wanted 1 %h", out_valid, exe_alu, exp2);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp;
      in_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         rand_data();
         rand_single_op();
         exp = model_result(exe_aluc, model_opa(), model_opb());
         #1;
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready_%0d: in_ready=%b, wanted 1", i, in_ready);
         end
         @(posedge clock);
         @(negedge clock);
         n_cmp++;
         if (out_valid !== 1'b1 || exe_alu !== exp) begin
            n_err++;
            $display("FAIL b2b_%0d: out_valid=%b exe_alu=%h, wanted 1 %h", i, out_valid, exe_alu, exp);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_flush_abort();
      logic [W-1:0] exp, prev;
      rand_data(); set_op(ALU_DIVU, SEL_REG, SEL_REG);
      exe_b = $urandom_range(1, 50);
      prev = exe_alu;
      accept_op("flush_div", exp);
      repeat (10) @(posedge clock);
      #1;
      flush = 1'b1;
      in_valid = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL flush_in_ready: in_ready=%b during flush, wanted 0", in_ready);
      end
      @(posedge clock);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || exe_alu !== prev || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL after_flush: out_valid=%b busy=%b exe_alu=%h in_ready=%b, wanted 0 0 %h 1",
                  out_valid, busy, exe_alu, in_ready, prev);
      end
      rand_data(); set_op(ALU_ADD, SEL_REG, SEL_REG);
      do_single("flush_next_add", exp);
      watch_no_stale("flush_div");
   endtask

   task automatic test_reset_abort();
      logic [W-1:0] exp;
      rand_data(); set_op(ALU_MULU, SEL_REG, SEL_REG);
      accept_op("reset_mul", exp);
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || exe_alu !== '0 || z !== 1'b1 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL after_reset_abort: out_valid=%b busy=%b exe_alu=%h z=%b in_ready=%b, wanted 0 0 0 1 1",
                  out_valid, busy, exe_alu, z, in_ready);
      end
      rand_data(); set_op(ALU_ADD, SEL_REG, SEL_SA_IMM);
      do_single("reset_next_add", exp);
      watch_no_stale("reset_mul");
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rand_data();
      set_op(ALU_ADD, SEL_REG, SEL_REG);
      test_reset();
      test_directed_single();
      test_random_single();
      test_muldiv();
      test_backpressure();
      test_back_to_back();
      test_flush_abort();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
